// File: rtl/tap_cmd_decoder.sv
// TAP command decoder: accepts 32-bit commands for TARGET_ID, updates per-channel
// compare/threshold/trigger registers, handshakes with the datapath and emits one status response.
module tap_cmd_decoder #(
    parameter int         N_CH      = 4,
    parameter int         THR_W     = 14,
    parameter logic [7:0] TARGET_ID = 8'h03,
    parameter int         TIMEOUT   = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [31:0]             cmd,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    output logic                    req,
    input  logic                    busy,
    output logic [N_CH-1:0]         ctl_gt,
    output logic [N_CH-1:0]         ctl_et,
    output logic [N_CH-1:0]         ctl_lt,
    output logic [N_CH-1:0]         ctl_trig_en,
    output logic [N_CH*THR_W-1:0]   ctl_thr,
    output logic                    rsp_valid,
    output logic [1:0]              rsp_status,
    output logic [15:0]             rsp_data,
    output logic [2:0]              dbg_state
);

    // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PARSE = 3'd1,
        REQ   = 3'd2,
        BUSY  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t             state_q, state_d;
    logic [31:0]        cmd_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               load_rsp;
    logic [1:0]         nxt_status;
    logic [15:0]        nxt_data;
    logic [15:0]        rd_val;
    logic [3:0]         ch;
    logic [3:0]         op;
    logic               is_rd, is_wr, bcast, ch_ok, wr_en, timed_out;
    logic               unused_cmd_bits;

    assign ch        = cmd_q[23:20];
    assign op        = cmd_q[19:16];
    assign is_rd     = (op == 4'd6) || (op == 4'd7);
    assign is_wr     = (op >= 4'd1) && (op <= 4'd5);
    assign bcast     = is_wr && (ch == 4'hF);
    assign ch_ok     = (ch < 4'(N_CH)) || bcast;
    assign wr_en     = (state_q == PARSE) && is_wr && ch_ok;
    assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign unused_cmd_bits = ^cmd_q;

    assign cmd_ready = (state_q == IDLE) && rst_n;
    assign req       = (state_q == REQ);
    assign rsp_valid = (state_q == DONE);
    assign dbg_state = state_q;

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch == 4'(i)) begin
                if (op == 4'd6)
                    rd_val = {12'b0, ctl_trig_en[i], ctl_lt[i], ctl_et[i], ctl_gt[i]};
                else
                    rd_val[THR_W-1:0] = ctl_thr[i*THR_W +: THR_W];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        load_rsp   = 1'b0;
        nxt_status = 2'b00;
        nxt_data   = '0;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready && cmd[31:24] == TARGET_ID)
                    state_d = PARSE;
            end
            PARSE: begin
                // Bad opcode outranks bad channel.
                if (!is_rd && !is_wr) begin
                    state_d = DONE; load_rsp = 1'b1; nxt_status = 2'b01;
                end else if (!ch_ok) begin
                    state_d = DONE; load_rsp = 1'b1; nxt_status = 2'b10;
                end else if (is_rd) begin
                    state_d = DONE; load_rsp = 1'b1; nxt_data = rd_val;
                end else begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (busy) begin
                    state_d = BUSY;
                end else if (timed_out) begin
                    state_d = DONE; load_rsp = 1'b1; nxt_status = 2'b11;
                end
            end
            BUSY: begin
                if (!busy) begin
                    state_d = DONE; load_rsp = 1'b1;
                end else if (timed_out) begin
                    state_d = DONE; load_rsp = 1'b1; nxt_status = 2'b11;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cmd_q      <= '0;
            cnt_q      <= '0;
            rsp_status <= 2'b00;
            rsp_data   <= '0;
        end else begin
            state_q <= state_d;
            if (cmd_valid && cmd_ready)
                cmd_q <= cmd;
            if ((state_d == REQ && state_q != REQ) || (state_d == BUSY && state_q != BUSY))
                cnt_q <= '0;
            else if (state_q == REQ || state_q == BUSY)
                cnt_q <= cnt_q + 1'b1;
            if (load_rsp) begin
                rsp_status <= nxt_status;
                rsp_data   <= nxt_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl_gt      <= '0;
            ctl_et      <= '0;
            ctl_lt      <= '0;
            ctl_trig_en <= '0;
            ctl_thr     <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < N_CH; i++) begin
                if (bcast || ch == 4'(i)) begin
                    case (op)
                        4'd1:    ctl_gt[i]      <= cmd_q[0];
                        4'd2:    ctl_et[i]      <= cmd_q[0];
                        4'd3:    ctl_lt[i]      <= cmd_q[0];
                        4'd4:    ctl_thr[i*THR_W +: THR_W] <= cmd_q[THR_W-1:0];
                        4'd5:    ctl_trig_en[i] <= cmd_q[0];
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_tap_cmd_decoder.sv
// Bench for tap_cmd_decoder: directed cases then random commands against a
// register-array model with arithmetic response timing.
module tb_tap_cmd_decoder;

    localparam int         N_CH    = 4;
    localparam int         THR_W   = 14;
    localparam int         TIMEOUT = 8;
    localparam logic [7:0] TID     = 8'h03;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [31:0]           cmd = '0;
    logic                  cmd_valid = 1'b0;
    logic                  busy = 1'b0;
    logic                  cmd_ready, req, rsp_valid;
    logic [N_CH-1:0]       ctl_gt, ctl_et, ctl_lt, ctl_trig_en;
    logic [N_CH*THR_W-1:0] ctl_thr;
    logic [1:0]            rsp_status;
    logic [15:0]           rsp_data;
    logic [2:0]            dbg_state;

    int total = 0;
    int bad   = 0;

    logic [N_CH-1:0]  m_gt, m_et, m_lt, m_trig;
    logic [THR_W-1:0] m_thr[N_CH];

    tap_cmd_decoder #(.N_CH(N_CH), .THR_W(THR_W), .TARGET_ID(TID), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .req(req), .busy(busy), .ctl_gt(ctl_gt), .ctl_et(ctl_et), .ctl_lt(ctl_lt),
        .ctl_trig_en(ctl_trig_en), .ctl_thr(ctl_thr), .rsp_valid(rsp_valid),
        .rsp_status(rsp_status), .rsp_data(rsp_data), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_gt = '0; m_et = '0; m_lt = '0; m_trig = '0;
        for (int i = 0; i < N_CH; i++) m_thr[i] = '0;
    endtask

    task automatic check_ctl(input string tag);
        logic [N_CH*THR_W-1:0] e_thr;
        for (int i = 0; i < N_CH; i++) e_thr[i*THR_W +: THR_W] = m_thr[i];
        check({tag, "_gt"},   ctl_gt, m_gt);
        check({tag, "_et"},   ctl_et, m_et);
        check({tag, "_lt"},   ctl_lt, m_lt);
        check({tag, "_trig"}, ctl_trig_en, m_trig);
        check({tag, "_thr"},  ctl_thr, e_thr);
    endtask

    // k: REQ cycle index at which busy rises (>= TIMEOUT means never); b: cycles busy stays high.
    task automatic run_cmd(input logic [31:0] c, input int k, input int b);
        logic [3:0]  ch, op;
        logic [15:0] d, e_data;
        logic [1:0]  e_status;
        logic        rd, wr;
        int          req_len, done_at;
        ch = c[23:20]; op = c[19:16]; d = c[15:0];
        rd = (op == 4'd6 || op == 4'd7);
        wr = (op >= 4'd1 && op <= 4'd5);
        e_data = '0;
        if (!rd && !wr)                    e_status = 2'b01;
        else if (wr && ch == 4'hF)         e_status = 2'b00;
        else if (int'(ch) < N_CH)          e_status = 2'b00;
        else                               e_status = 2'b10;
        if (rd && e_status == 2'b00) begin
            if (op == 4'd6) e_data = {12'b0, m_trig[ch], m_lt[ch], m_et[ch], m_gt[ch]};
            else            e_data = 16'(m_thr[ch]);
        end

        cmd = c; cmd_valid = 1'b1;
        @(negedge clk);
        check("ready_idle", cmd_ready, 1'b1);
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd = $urandom;
        @(negedge clk);
        if (c[31:24] != TID) begin
            check("fgn_ready", cmd_ready, 1'b1);
            check("fgn_req", req, 1'b0);
            check("fgn_rsp", rsp_valid, 1'b0);
            check_ctl("fgn");
            @(posedge clk); #1;
            return;
        end
        check("parse_ready", cmd_ready, 1'b0);
        check("parse_rsp", rsp_valid, 1'b0);
        check("parse_req", req, 1'b0);

        if (wr && e_status == 2'b00) begin
            for (int i = 0; i < N_CH; i++) begin
                if (ch == 4'hF || int'(ch) == i) begin
                    case (op)
                        4'd1: m_gt[i]   = d[0];
                        4'd2: m_et[i]   = d[0];
                        4'd3: m_lt[i]   = d[0];
                        4'd4: m_thr[i]  = d[THR_W-1:0];
                        4'd5: m_trig[i] = d[0];
                        default: ;
                    endcase
                end
            end
            if (k < TIMEOUT) begin
                req_len  = k + 1;
                done_at  = k + ((b < TIMEOUT) ? b : TIMEOUT) + 1;
                e_status = (b <= TIMEOUT) ? 2'b00 : 2'b11;
            end else begin
                req_len  = TIMEOUT;
                done_at  = TIMEOUT;
                e_status = 2'b11;
            end
            @(posedge clk); #1;
            for (int j = 0; j <= done_at; j++) begin
                busy = (j >= k) && (j < k + b);
                @(negedge clk);
                if (j == 0) check_ctl("wr");
                check("wr_req", req, (j < req_len));
                check("wr_rsp_valid", rsp_valid, (j == done_at));
                if (j < done_at) begin
                    @(posedge clk); #1;
                end
            end
            check("wr_status", rsp_status, e_status);
            check("wr_data", rsp_data, 16'h0);
            check_ctl("wr_done");
        end else begin
            @(posedge clk); #1;
            @(negedge clk);
            check("rd_rsp_valid", rsp_valid, 1'b1);
            check("rd_req", req, 1'b0);
            check("rd_status", rsp_status, e_status);
            check("rd_data", rsp_data, e_data);
            check_ctl("rd");
        end
        @(posedge clk); #1;
        busy = 1'b0;
        @(negedge clk);
        check("ready_after", cmd_ready, 1'b1);
        check("rsp_drop", rsp_valid, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0]  tgt;
        logic [3:0]  ch, op;
        int          k, b;
        model_reset();

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", cmd_ready, 1'b0);
        check("rst_req", req, 1'b0);
        check("rst_rsp", rsp_valid, 1'b0);
        check("rst_status", rsp_status, 2'b00);
        check("rst_data", rsp_data, 16'h0);
        check_ctl("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_ready", cmd_ready, 1'b1);
        @(posedge clk); #1;

        run_cmd({TID, 4'd2, 4'd4, 16'h3ABC}, 1, 3);
        check("thr_ch2", ctl_thr[2*THR_W +: THR_W], 14'h3ABC);
        run_cmd({TID, 4'hF, 4'd5, 16'h0001}, 0, 1);
        check("bcast_trig", ctl_trig_en, 4'b1111);
        run_cmd({TID, 4'd1, 4'd6, 16'h0000}, 0, 1);
        check("flags_ch1", rsp_data, 16'h0008);
        run_cmd({TID, 4'd0, 4'd9, 16'h0001}, 0, 1);
        check("bad_op", rsp_status, 2'b01);
        run_cmd({TID, 4'd5, 4'd1, 16'h0001}, 0, 1);
        check("bad_ch", rsp_status, 2'b10);
        run_cmd({TID, 4'hF, 4'd7, 16'h0000}, 0, 1);
        check("bcast_read", rsp_status, 2'b10);
        run_cmd({TID, 4'd9, 4'd0, 16'h0000}, 0, 1);
        run_cmd({8'h01, 4'd0, 4'd1, 16'h0001}, 0, 1);
        run_cmd({TID, 4'd3, 4'd1, 16'h0001}, 100, 0);
        check("req_timeout", rsp_status, 2'b11);
        run_cmd({TID, 4'd3, 4'd6, 16'h0000}, 0, 1);
        check("retained", rsp_data, 16'h0009);
        run_cmd({TID, 4'd0, 4'd3, 16'h0001}, 0, 12);
        run_cmd({TID, 4'd1, 4'd2, 16'h0001}, 2, TIMEOUT);

        // Reset while the datapath holds busy.
        cmd = {TID, 4'd1, 4'd4, 16'h1234}; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        m_thr[1] = 14'h1234;
        @(posedge clk); #1;
        busy = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_req_low", req, 1'b0);
        check("mid_rsp_low", rsp_valid, 1'b0);
        check_ctl("mid");
        @(posedge clk); #1;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        check("mid_rst_ready", cmd_ready, 1'b0);
        check("mid_rst_req", req, 1'b0);
        check("mid_rst_rsp", rsp_valid, 1'b0);
        check("mid_rst_status", rsp_status, 2'b00);
        check_ctl("mid_rst");
        @(posedge clk); #1;
        rst_n = 1'b1; busy = 1'b0;
        @(negedge clk);
        check("mid_rel_ready", cmd_ready, 1'b1);
        check("mid_rel_req", req, 1'b0);
        @(posedge clk); #1;

        for (int n = 0; n < 80; n++) begin
            tgt = ($urandom_range(0, 9) == 0) ? 8'h01 : TID;
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: ch = 4'($urandom_range(0, N_CH - 1));
                6, 7:             ch = 4'hF;
                default:          ch = 4'($urandom_range(N_CH, 14));
            endcase
            op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
            k  = ($urandom_range(0, 5) == 0) ? 20 : $urandom_range(0, 4);
            b  = $urandom_range(1, 10);
            run_cmd({tgt, ch, op, 16'($urandom_range(0, 65535))}, k, b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
